// File: rtl/spi_byte_master_if.sv
// Requester and SPI pin bundle for spi_byte_master.
// The slave modport is the engine's view. The master modport is the bridge and flash side.
interface spi_byte_master_if;
  logic       i_start;
  logic [7:0] i_din;
  logic       o_bsy;
  logic [7:0] o_dout;
  logic       i_miso;
  logic       o_mosi;
  logic       o_sck;

  modport slave  (input  i_start, i_din, i_miso,
                  output o_bsy, o_dout, o_mosi, o_sck);
  modport master (output i_start, i_din, i_miso,
                  input  o_bsy, o_dout, o_mosi, o_sck);
endinterface

// File: rtl/spi_byte_master.sv
// Byte-wide SPI master: shifts one byte out MSB-first on mosi and captures miso, mode 0 by default.
// Define SPI_BYTE_MASTER_MODE3_EN for mode 3, where sck idles high outside the shift phases.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_byte_master_if.slave  bus
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_byte_master: CLK_DIV must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
`ifdef SPI_BYTE_MASTER_MODE3_EN
  localparam logic SCK_IDLE = 1'b1;
`else
  localparam logic SCK_IDLE = 1'b0;
`endif

  state_t     r_state, w_state_nxt;
  logic [7:0] r_div_cnt, w_div_cnt_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_tx_sh, w_tx_sh_nxt;
  logic [7:0] r_rx_sh, w_rx_sh_nxt;
  logic [7:0] r_dout, w_dout_nxt;
  logic       r_bsy, w_bsy_nxt;
  logic       r_sck, w_sck_nxt;
  logic       w_div_last;

  assign w_div_last = (r_div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_LOW;
      S_LOW:   if (w_div_last)  w_state_nxt = S_HIGH;
      S_HIGH:  if (w_div_last)  w_state_nxt = (r_bit_cnt == 3'd7) ? S_DONE : S_LOW;
      S_DONE:                   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_div_cnt_nxt = r_div_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_sh_nxt   = r_tx_sh;
    w_rx_sh_nxt   = r_rx_sh;
    w_dout_nxt    = r_dout;
    w_bsy_nxt     = r_bsy;
    w_sck_nxt     = r_sck;
    unique case (r_state)
      S_IDLE: begin
        w_bsy_nxt = 1'b0;
        w_sck_nxt = SCK_IDLE;
        if (bus.i_start) begin
          w_tx_sh_nxt   = bus.i_din;
          w_bit_cnt_nxt = 3'd0;
          w_div_cnt_nxt = 8'd0;
          w_bsy_nxt     = 1'b1;
          w_sck_nxt     = 1'b0;
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          // miso is captured on the same edge that raises sck.
          w_sck_nxt     = 1'b1;
          w_rx_sh_nxt   = {r_rx_sh[6:0], bus.i_miso};
          w_div_cnt_nxt = 8'd0;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_div_cnt_nxt = 8'd0;
          if (r_bit_cnt == 3'd7) begin
            // Load DOUT on entry to DONE so it is stable for the whole last bsy cycle.
            w_dout_nxt = r_rx_sh;
            w_sck_nxt  = SCK_IDLE;
          end else begin
            w_sck_nxt     = 1'b0;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_tx_sh_nxt   = {r_tx_sh[6:0], 1'b0};
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_bsy_nxt = 1'b0;
        w_sck_nxt = SCK_IDLE;
      end
      default: begin
        w_bsy_nxt = 1'b0;
        w_sck_nxt = SCK_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_tx_sh   <= 8'd0;
      r_rx_sh   <= 8'd0;
      r_dout    <= 8'd0;
      r_bsy     <= 1'b0;
      r_sck     <= SCK_IDLE;
    end else begin
      r_div_cnt <= w_div_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx_sh   <= w_tx_sh_nxt;
      r_rx_sh   <= w_rx_sh_nxt;
      r_dout    <= w_dout_nxt;
      r_bsy     <= w_bsy_nxt;
      r_sck     <= w_sck_nxt;
    end
  end

  assign bus.o_mosi = r_tx_sh[7];
  assign bus.o_sck  = r_sck;
  assign bus.o_bsy  = r_bsy;
  assign bus.o_dout = r_dout;

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: two instances (CLK_DIV 4 and 1), each watched by a monitor.
// The monitor checks transfer length, sck rise count, mosi bits, DOUT timing and the gap between transfers.
`timescale 1ns/1ps
module tb_spi_byte_master;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
`ifdef SPI_BYTE_MASTER_MODE3_EN
  localparam logic IDLE_SCK = 1'b1;
`else
  localparam logic IDLE_SCK = 1'b0;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    int         len;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_byte_master_if if_a ();
  spi_byte_master_if if_b ();

  spi_byte_master #(.CLK_DIV(DIV_A)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  spi_byte_master #(.CLK_DIV(DIV_B)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  int checks = 0;
  int errors = 0;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] miso_q[$];

  // Flash model for instance A: the next bit is presented after each sck fall.
  logic       loopback = 1'b0;
  logic       miso_model = 1'b0;
  logic [7:0] miso_byte = 8'h00;
  int         miso_idx = 7;
  bit         miso_armed = 1'b0;

  assign if_a.i_miso = loopback ? if_a.o_mosi : miso_model;
  assign if_b.i_miso = 1'b0;

  always @(posedge if_a.o_bsy) begin
    miso_byte  = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
    miso_idx   = 7;
    miso_armed = 1'b0;
    miso_model = miso_byte[7];
  end
  always @(negedge if_a.o_bsy) miso_armed = 1'b0;
  always @(posedge if_a.o_sck) if (if_a.o_bsy) miso_armed = 1'b1;
  always @(negedge if_a.o_sck) begin
    if (miso_armed && miso_idx > 0) begin
      miso_idx   = miso_idx - 1;
      miso_model = miso_byte[miso_idx];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-instance monitor state, indexed by instance (0 = A, 1 = B).
  int         m_len[2];
  int         m_rises[2];
  int         m_gap[2];
  int         m_gap_at_start[2];
  logic       m_prev_bsy[2];
  logic       m_prev_sck[2];
  logic [7:0] m_mosi_bits[2];
  logic [7:0] m_last_dout[2];

  task automatic mon_step(input int id, input logic bsy, input logic sck,
                          input logic mosi, input logic [7:0] dout);
    exp_t e;
    bit   have;
    string tag;
    tag = (id == 0) ? "a" : "b";
    if (!rst) begin
      m_prev_bsy[id] = 1'b0;
      m_prev_sck[id] = IDLE_SCK;
      m_len[id]      = 0;
      m_rises[id]    = 0;
      m_gap[id]      = -1;
      return;
    end
    if (bsy) begin
      if (!m_prev_bsy[id]) begin
        m_len[id]          = 0;
        m_rises[id]        = 0;
        m_mosi_bits[id]    = 8'h00;
        m_gap_at_start[id] = m_gap[id];
      end
      m_len[id]++;
      if (sck && !m_prev_sck[id]) begin
        m_rises[id]++;
        m_mosi_bits[id] = {m_mosi_bits[id][6:0], mosi};
      end
      m_last_dout[id] = dout;
    end else begin
      check({"idle_sck_", tag}, sck, IDLE_SCK);
      if (m_prev_bsy[id]) begin
        have = 1'b0;
        if (id == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
        if (id == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer_%s: got a transfer, expected none at %0t", tag, $time);
        end else begin
          check({"bsy_len_", tag},    m_len[id],       e.len);
          check({"sck_rises_", tag},  m_rises[id],     8);
          check({"mosi_byte_", tag},  m_mosi_bits[id], e.din);
          check({"dout_done_", tag},  m_last_dout[id], e.dout);
          check({"dout_after_", tag}, dout,            e.dout);
          if (e.gap >= 0) check({"gap_", tag}, m_gap_at_start[id], e.gap);
        end
        m_gap[id] = 0;
      end
      if (m_gap[id] >= 0) m_gap[id]++;
    end
    m_prev_bsy[id] = bsy;
    m_prev_sck[id] = sck;
  endtask

  always @(negedge clk) begin
    mon_step(0, if_a.o_bsy, if_a.o_sck, if_a.o_mosi, if_a.o_dout);
    mon_step(1, if_b.o_bsy, if_b.o_sck, if_b.o_mosi, if_b.o_dout);
  end

  task automatic start_a(input logic [7:0] din, input logic [7:0] mb, input bit push, input int gap);
    if (push) begin
      q_a.push_back('{din: din, dout: (loopback ? din : mb), len: 16*DIV_A+1, gap: gap});
      miso_q.push_back(mb);
    end
    if_a.i_din   = din;
    if_a.i_start = 1'b1;
    for (int i = 0; i < 10 && !if_a.o_bsy; i++) begin
      @(posedge clk); #1;
    end
    check("start_ack_a", if_a.o_bsy, 1'b1);
    if_a.i_start = 1'b0;
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 300 && if_a.o_bsy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_a", if_a.o_bsy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_sck;
    int   rises;
    if_a.i_start = 1'b0; if_a.i_din = 8'h00;
    if_b.i_start = 1'b0; if_b.i_din = 8'h00;
    #1;
    check("rst_bsy_a",  if_a.o_bsy,  1'b0);
    check("rst_sck_a",  if_a.o_sck,  IDLE_SCK);
    check("rst_mosi_a", if_a.o_mosi, 1'b0);
    check("rst_dout_a", if_a.o_dout, 8'h00);
    check("rst_sck_b",  if_b.o_sck,  IDLE_SCK);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // CLK_DIV=4: A5 out, 3C in.
    start_a(8'hA5, 8'h3C, 1'b1, -1);
    wait_idle_a();

    // CLK_DIV=1: FF out, constant 0 in.
    q_b.push_back('{din: 8'hFF, dout: 8'h00, len: 16*DIV_B+1, gap: -1});
    if_b.i_din = 8'hFF; if_b.i_start = 1'b1;
    for (int i = 0; i < 10 && !if_b.o_bsy; i++) begin
      @(posedge clk); #1;
    end
    check("start_ack_b", if_b.o_bsy, 1'b1);
    if_b.i_start = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    // Back-to-back with start held; DIN changes mid-flight for the next byte.
    q_a.push_back('{din: 8'h01, dout: 8'h81, len: 16*DIV_A+1, gap: -1});
    q_a.push_back('{din: 8'h80, dout: 8'h7E, len: 16*DIV_A+1, gap: 1});
    miso_q.push_back(8'h81);
    miso_q.push_back(8'h7E);
    if_a.i_din = 8'h01; if_a.i_start = 1'b1;
    for (int i = 0; i < 10 && !if_a.o_bsy; i++) begin
      @(posedge clk); #1;
    end
    if_a.i_din = 8'h80;
    for (int i = 0; i < 100 && if_a.o_bsy; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10 && !if_a.o_bsy; i++) begin
      @(posedge clk); #1;
    end
    check("b2b_second_start", if_a.o_bsy, 1'b1);
    if_a.i_start = 1'b0;
    wait_idle_a();

    // Start pulse during an active transfer is ignored.
    start_a(8'hC3, 8'h96, 1'b1, -1);
    repeat (9) @(posedge clk);
    #1;
    if_a.i_din = 8'hFF; if_a.i_start = 1'b1;
    @(posedge clk); #1;
    if_a.i_start = 1'b0;
    wait_idle_a();
    repeat (6) @(posedge clk);
    #1;

    // Reset after 3 sck rises aborts the transfer.
    start_a(8'h33, 8'h00, 1'b0, -1);
    rises = 0;
    prev_sck = if_a.o_sck;
    for (int i = 0; i < 200 && rises < 3; i++) begin
      @(negedge clk);
      if (if_a.o_sck && !prev_sck) rises++;
      prev_sck = if_a.o_sck;
    end
    check("abort_rises", rises, 3);
    #2 rst = 1'b0;
    #1;
    check("abort_bsy",  if_a.o_bsy,  1'b0);
    check("abort_sck",  if_a.o_sck,  IDLE_SCK);
    check("abort_mosi", if_a.o_mosi, 1'b0);
    check("abort_dout", if_a.o_dout, 8'h00);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_a(8'hE7, 8'h18, 1'b1, -1);
    wait_idle_a();

    // Loopback: DOUT equals DIN.
    loopback = 1'b1;
    start_a(8'h5A, 8'h00, 1'b1, -1);
    wait_idle_a();
    loopback = 1'b0;
    check("idle_sck_end_a", if_a.o_sck, IDLE_SCK);

    check("sb_a_drained", q_a.size(), 0);
    check("sb_b_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
